// File: rtl/wb_trace_checker.sv
// Checks the core's register-file write-back stream in order against a preloaded
// table of expected writes and reports pass/fail, match count and the first mismatch.
module wb_trace_checker #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 5,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     exp_we,
    input  logic [AW-1:0]            exp_addr,
    input  logic [DW-1:0]            exp_data,
    output logic                     exp_full,
    input  logic                     start,
    input  logic                     wb_we,
    input  logic [AW-1:0]            wb_addr,
    input  logic [DW-1:0]            wb_data,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic                     timeout,
    output logic [$clog2(DEPTH):0]   match_cnt,
    output logic [$clog2(DEPTH)-1:0] fail_idx,
    output logic [AW-1:0]            fail_addr,
    output logic [DW-1:0]            fail_data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PASS = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    match_q, match_d;
    logic [TW-1:0]    idle_q, idle_d;
    logic             timeout_q, timeout_d;
    logic [PW-1:0]    fidx_q, fidx_d;
    logic [AW-1:0]    faddr_q, faddr_d;
    logic [DW-1:0]    fdata_q, fdata_d;

    logic [AW+DW-1:0] table_q [DEPTH];

    logic push_ok;
    logic wb_real;
    logic hit;

    assign push_ok = (state_q == S_IDLE) && exp_we && (count_q != CW'(DEPTH));
    // Writes to $zero are architecturally void and never take part in the check.
    assign wb_real = wb_we && (wb_addr != '0);
    assign hit     = wb_real && ({wb_addr, wb_data} == table_q[rd_ptr_q]);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        match_d   = match_q;
        idle_d    = idle_q;
        timeout_d = timeout_q;
        fidx_d    = fidx_q;
        faddr_d   = faddr_q;
        fdata_d   = fdata_q;

        if (clear) begin
            state_d   = S_IDLE;
            count_d   = '0;
            rd_ptr_d  = '0;
            match_d   = '0;
            idle_d    = '0;
            timeout_d = 1'b0;
            fidx_d    = '0;
            faddr_d   = '0;
            fdata_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (push_ok) count_d = count_q + CW'(1);
                    // A push in the same cycle as start extends the run it begins.
                    if (start) begin
                        rd_ptr_d = '0;
                        idle_d   = '0;
                        state_d  = (count_d == '0) ? S_PASS : S_RUN;
                    end
                end
                S_RUN: begin
                    if (hit) begin
                        match_d  = match_q + CW'(1);
                        rd_ptr_d = rd_ptr_q + PW'(1);
                        idle_d   = '0;
                        if ({1'b0, rd_ptr_q} + CW'(1) == count_q) state_d = S_PASS;
                    end else if (wb_real) begin
                        state_d = S_FAIL;
                        fidx_d  = rd_ptr_q;
                        faddr_d = wb_addr;
                        fdata_d = wb_data;
                    end else if (idle_q == TW'(TIMEOUT - 1)) begin
                        state_d   = S_FAIL;
                        timeout_d = 1'b1;
                        fidx_d    = rd_ptr_q;
                        faddr_d   = '0;
                        fdata_d   = '0;
                    end else begin
                        idle_d = idle_q + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            match_q   <= '0;
            idle_q    <= '0;
            timeout_q <= 1'b0;
            fidx_q    <= '0;
            faddr_q   <= '0;
            fdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            match_q   <= match_d;
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
            fidx_q    <= fidx_d;
            faddr_q   <= faddr_d;
            fdata_q   <= fdata_d;
        end
    end

    // Table contents carry no reset; only count decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) table_q[count_q[PW-1:0]] <= {exp_addr, exp_data};
    end

    assign exp_full  = (count_q == CW'(DEPTH));
    assign busy      = (state_q == S_RUN);
    assign pass      = (state_q == S_PASS);
    assign fail      = (state_q == S_FAIL);
    assign done      = pass || fail;
    assign timeout   = timeout_q;
    assign match_cnt = match_q;
    assign fail_idx  = fidx_q;
    assign fail_addr = faddr_q;
    assign fail_data = fdata_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker: expected status words are queued when the
// stimulus is driven and popped against the DUT outputs after the deciding edge.
module tb_wb_trace_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_full;
    logic        start;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy, done, pass, fail, timeout;
    logic [4:0]  match_cnt;
    logic [3:0]  fail_idx;
    logic [4:0]  fail_addr;
    logic [31:0] fail_data;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [51:0] val;
    } exp_t;

    exp_t sb[$];

    wb_trace_checker #(
        .DEPTH(16), .AW(5), .DW(32), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .exp_full(exp_full),
        .start(start), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .match_cnt(match_cnt), .fail_idx(fail_idx), .fail_addr(fail_addr),
        .fail_data(fail_data)
    );

    always #5 clk = ~clk;

    function automatic logic [51:0] mk(input logic b, input logic d, input logic p,
                                       input logic f, input logic t, input logic [4:0] mc,
                                       input logic [3:0] fi, input logic [4:0] fa,
                                       input logic [31:0] fd, input logic full);
        return {b, d, p, f, t, mc, fi, fa, fd, full};
    endfunction

    function automatic logic [51:0] st_idle(input logic full);
        return mk(0, 0, 0, 0, 0, 5'd0, 4'd0, 5'd0, 32'd0, full);
    endfunction

    function automatic logic [51:0] st_run(input logic [4:0] mc, input logic full);
        return mk(1, 0, 0, 0, 0, mc, 4'd0, 5'd0, 32'd0, full);
    endfunction

    function automatic logic [51:0] st_pass(input logic [4:0] mc, input logic full);
        return mk(0, 1, 1, 0, 0, mc, 4'd0, 5'd0, 32'd0, full);
    endfunction

    function automatic logic [51:0] st_fail(input logic [4:0] mc, input logic [3:0] fi,
                                            input logic [4:0] fa, input logic [31:0] fd);
        return mk(0, 1, 0, 1, 0, mc, fi, fa, fd, 1'b0);
    endfunction

    function automatic logic [51:0] observed();
        return {busy, done, pass, fail, timeout, match_cnt, fail_idx, fail_addr,
                fail_data, exp_full};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string tag, input logic [51:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check_st();
        exp_t e;
        logic [51:0] obs;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=%h required=<entry>", observed());
        end else begin
            e = sb.pop_front();
            obs = observed();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        exp_we = 1'b1; exp_addr = a; exp_data = d;
        tick();
        exp_we = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic push3();
        push(5'd1, 32'h11);
        push(5'd2, 32'h22);
        push(5'd3, 32'h33);
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
        start = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        tick(); tick();
        expect_st("reset_state", st_idle(0)); check_st();
        rst = 1'b1;
        tick();

        // Clean three-write run
        push3();
        expect_st("after_push3", st_idle(0)); check_st();
        do_start();
        expect_st("run_started", st_run(5'd0, 0)); check_st();
        wr(5'd1, 32'h11);
        expect_st("run_first_match", st_run(5'd1, 0)); check_st();
        wr(5'd2, 32'h22);
        wr(5'd3, 32'h33);
        expect_st("pass_three", st_pass(5'd3, 0)); check_st();
        wr(5'd5, 32'h55);
        expect_st("pass_sticky", st_pass(5'd3, 0)); check_st();
        do_clear();

        // Data mismatch on the second write
        push3();
        do_start();
        wr(5'd1, 32'h11);
        wr(5'd2, 32'h23);
        expect_st("mismatch_fail", st_fail(5'd1, 4'd1, 5'd2, 32'h23)); check_st();
        wr(5'd3, 32'h33);
        expect_st("fail_sticky", st_fail(5'd1, 4'd1, 5'd2, 32'h23)); check_st();
        do_clear();
        expect_st("clear_from_fail", st_idle(0)); check_st();

        // $zero writes and idle gaps are tolerated
        push3();
        do_start();
        for (int i = 1; i <= 3; i++) begin
            wr(5'd0, 32'hDEADBEEF);
            repeat (10) tick();
            wr(5'(i), 32'(i * 'h11));
        end
        expect_st("zero_writes_pass", st_pass(5'd3, 0)); check_st();
        do_clear();

        // Timeout: one entry, no writes
        push(5'd1, 32'h11);
        do_start();
        repeat (63) tick();
        expect_st("timeout_not_yet", st_run(5'd0, 0)); check_st();
        tick();
        expect_st("timeout_fail", mk(0, 1, 0, 1, 1, 5'd0, 4'd0, 5'd0, 32'd0, 0)); check_st();
        do_clear();

        // A write landing on the timeout threshold wins
        push(5'd1, 32'h11);
        push(5'd2, 32'h22);
        do_start();
        repeat (63) tick();
        wr(5'd1, 32'h11);
        expect_st("write_beats_timeout", st_run(5'd1, 0)); check_st();
        do_clear();

        // Table fill: 17th push dropped, run length is 16
        for (int i = 0; i < 15; i++) push(5'(i + 1), 32'(i * 'h101 + 1));
        expect_st("fill_15", st_idle(0)); check_st();
        push(5'd16, 32'(15 * 'h101 + 1));
        expect_st("fill_16_full", st_idle(1)); check_st();
        push(5'd17, 32'hBAD0BAD0);
        expect_st("fill_17_dropped", st_idle(1)); check_st();
        do_start();
        for (int i = 0; i < 16; i++) wr(5'(i + 1), 32'(i * 'h101 + 1));
        expect_st("full_table_pass", st_pass(5'd16, 1)); check_st();
        do_clear();
        expect_st("clear_empties", st_idle(0)); check_st();
        do_start();
        expect_st("empty_start_pass", st_pass(5'd0, 0)); check_st();
        do_clear();

        // Push and start in the same cycle
        exp_we = 1'b1; exp_addr = 5'd7; exp_data = 32'h77; start = 1'b1;
        tick();
        exp_we = 1'b0; start = 1'b0;
        expect_st("push_with_start", st_run(5'd0, 0)); check_st();
        wr(5'd7, 32'h77);
        expect_st("push_with_start_pass", st_pass(5'd1, 0)); check_st();
        do_clear();

        // Asynchronous reset mid-run
        push3();
        do_start();
        wr(5'd1, 32'h11);
        #2 rst = 1'b0;
        #1;
        expect_st("async_reset", st_idle(0)); check_st();
        tick();
        rst = 1'b1;
        tick();

        // Fail, clear, then a fresh push is accepted
        push(5'd1, 32'h11);
        do_start();
        wr(5'd1, 32'h12);
        expect_st("fail_idx0", st_fail(5'd0, 4'd0, 5'd1, 32'h12)); check_st();
        do_clear();
        expect_st("clear_after_fail", st_idle(0)); check_st();
        push(5'd4, 32'h44);
        do_start();
        wr(5'd4, 32'h44);
        expect_st("push_after_clear", st_pass(5'd1, 0)); check_st();

        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
